// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for a shared 8-bit sequential ALU.
// Sequences clear/begin/operands onto the ALU and returns a 16-bit result per requester.
module alu_req_scheduler #(
    parameter int unsigned A_CYC  = 1,
    parameter int unsigned B_CYC  = 3,
    parameter int unsigned LAT_AS = 12,
    parameter int unsigned LAT_MD = 40,
    parameter int unsigned CNT_W  = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        alu_rst,
    output logic        alu_begin,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       a_q, a_d, b_q, b_d, lo_q, lo_d;
    logic             pick1;
    logic             gnt0_d, gnt1_d, done_d, alu_rst_d, alu_begin_d;
    logic [7:0]       inbus_d;
    logic [15:0]      res_d;

    assign pick1  = req1 && (!req0 || ptr_q);
    assign alu_op = op_q;

    // Outputs are registered, so ALU-facing strobes are decoded from cyc_q one
    // cycle early; alu_outbus is sampled directly, hence the +1 on its indices.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done_d      = 1'b0;
        alu_rst_d   = 1'b0;
        alu_begin_d = 1'b0;
        inbus_d     = '0;
        res_d       = '0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick1;
                    ptr_d   = !pick1;
                    op_d    = pick1 ? op1 : op0;
                    a_d     = pick1 ? a1 : a0;
                    b_d     = pick1 ? b1 : b0;
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    state_d = CLR;
                end
            end
            CLR: begin
                alu_rst_d = 1'b1;
                cyc_d     = '0;
                state_d   = RUN;
            end
            RUN: begin
                cyc_d       = cyc_q + CNT_W'(1);
                alu_begin_d = (cyc_q == '0);
                if (cyc_q == CNT_W'(A_CYC))
                    inbus_d = a_q;
                else if (cyc_q == CNT_W'(B_CYC))
                    inbus_d = b_q;
                if (!op_q[1]) begin
                    if (cyc_q == CNT_W'(LAT_AS + 1)) begin
                        res_d   = {8'h00, alu_outbus};
                        done_d  = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    if (cyc_q == CNT_W'(LAT_MD + 1))
                        lo_d = alu_outbus;
                    if (cyc_q == CNT_W'(LAT_MD + 2)) begin
                        res_d   = {alu_outbus, lo_q};
                        done_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            res0      <= '0;
            res1      <= '0;
            alu_rst   <= 1'b0;
            alu_begin <= 1'b0;
            alu_inbus <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lo_q      <= lo_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done_d && !owner_q;
            done1     <= done_d && owner_q;
            if (done_d && !owner_q)
                res0 <= res_d;
            if (done_d && owner_q)
                res1 <= res_d;
            alu_rst   <= alu_rst_d;
            alu_begin <= alu_begin_d;
            alu_inbus <= inbus_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: bench ALU model plus a done-driven scoreboard monitor.
module tb_alu_req_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [7:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, alu_rst, alu_begin, busy;
    logic [15:0] res0, res1;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus = '0;

    alu_req_scheduler #(
        .A_CYC(1), .B_CYC(3), .LAT_AS(12), .LAT_MD(40), .CNT_W(6)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .alu_rst(alu_rst), .alu_begin(alu_begin), .alu_op(alu_op),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int unsigned cycle = 0;
    always @(posedge CLK) cycle <= cycle + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          who;
        logic [15:0] res;
        int unsigned cyc;
    } exp_t;
    exp_t sbq[$];

    logic [48:0] outs;
    assign outs = {gnt0, gnt1, done0, done1, res0, res1, alu_rst, alu_begin, alu_op, alu_inbus, busy};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Bench ALU: result appears on alu_outbus at run-cycle 12 (add/sub) or 40/41 (mul/div lo/hi).
    logic [1:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_res;
    int          m_k;
    bit          m_run = 1'b0;
    always @(posedge CLK) begin
        #1;
        alu_outbus = '0;
        if (!RST_N || alu_rst) begin
            m_run = 1'b0;
        end else begin
            if (alu_begin) begin
                m_run = 1'b1;
                m_k   = 0;
                m_op  = alu_op;
            end else if (m_run) begin
                m_k++;
            end
            if (m_run) begin
                if (m_k == 1) m_a = alu_inbus;
                if (m_k == 3) m_b = alu_inbus;
                case (m_op)
                    2'b00: m_res = {8'h00, m_a + m_b};
                    2'b01: m_res = {8'h00, m_a - m_b};
                    2'b10: m_res = 16'(m_a) * 16'(m_b);
                    default: m_res = (m_b == 0) ? 16'hFFFF : {m_a % m_b, m_a / m_b};
                endcase
                if (!m_op[1] && m_k == 12) begin
                    alu_outbus = m_res[7:0];
                    m_run = 1'b0;
                end
                if (m_op[1] && m_k == 40) alu_outbus = m_res[7:0];
                if (m_op[1] && m_k == 41) begin
                    alu_outbus = m_res[15:8];
                    m_run = 1'b0;
                end
            end
        end
    end

    // Monitor: every done pops one expectation; results must not move without a done.
    exp_t        e;
    logic [15:0] prev0 = '0, prev1 = '0;
    always @(negedge CLK) begin
        if (RST_N) begin
            if (done0 || done1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", {62'd0, done1, done0}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_owner", {62'd0, done1, done0}, (e.who == 1) ? 64'd2 : 64'd1);
                    chk("done_res", (e.who == 1) ? res1 : res0, e.res);
                    chk("done_cycle", cycle, e.cyc);
                end
            end
            if (!done0 && res0 !== prev0) chk("res0_hold", res0, prev0);
            if (!done1 && res1 !== prev1) chk("res1_hold", res1, prev1);
        end
        prev0 = res0;
        prev1 = res1;
    end

    task automatic wait_gnt(output int who, output int unsigned g);
        who = -1;
        g   = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (gnt0 || gnt1) begin
                if (gnt0 && gnt1) chk("gnt_onehot", {62'd0, gnt1, gnt0}, 64'd1);
                who = gnt1 ? 1 : 0;
                g   = cycle;
                break;
            end
        end
        if (who < 0) chk("gnt_timeout", 64'd1, 64'd0);
    endtask

    task automatic expect_done(input int who, input logic [15:0] res, input int unsigned cyc);
        exp_t x;
        x.who = who;
        x.res = res;
        x.cyc = cyc;
        sbq.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge CLK);
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    int          who;
    int unsigned g, g_prev;
    logic [15:0] rr_res [4] = '{16'h0005, 16'h0005, 16'h0000, 16'hFE01};
    int unsigned rr_lat [4] = '{15, 15, 15, 44};

    initial begin
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 64'(outs), 64'd0);

        // Both requesters high out of reset, held for four operations.
        op0 = 2'b01; a0 = 8'd9; b0 = 8'd4;
        op1 = 2'b01; a1 = 8'd9; b1 = 8'd4;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(who, g);
            chk("rr_order", 64'(who), 64'(k % 2));
            if (k > 0) chk("b2b_gap", 64'(g - g_prev), 64'd17);
            expect_done(k % 2, rr_res[k], g + rr_lat[k]);
            g_prev = g;
            case (k)
                0: begin op0 = 2'b00; a0 = 8'hFF; b0 = 8'h01; end
                1: begin op1 = 2'b10; a1 = 8'hFF; b1 = 8'hFF; end
                2: req0 = 1'b0;
                default: req1 = 1'b0;
            endcase
        end
        drain();

        // Single add: detailed sequencing.
        req0 = 1'b1; op0 = 2'b00; a0 = 8'd5; b0 = 8'd3;
        wait_gnt(who, g);
        req0 = 1'b0;
        chk("t1_owner", 64'(who), 64'd0);
        chk("t1_busy_at_gnt", {63'd0, busy}, 64'd1);
        expect_done(0, 16'h0008, g + 15);
        @(negedge CLK);
        chk("t1_alu_rst", {63'd0, alu_rst}, 64'd1);
        chk("t1_alu_op", {62'd0, alu_op}, 64'd0);
        @(negedge CLK);
        chk("t1_alu_begin", {62'd0, alu_begin, alu_rst}, 64'd2);
        @(negedge CLK);
        chk("t1_inbus_a", {56'd0, alu_inbus}, 64'd5);
        @(negedge CLK);
        chk("t1_inbus_idle", {56'd0, alu_inbus}, 64'd0);
        @(negedge CLK);
        chk("t1_inbus_b", {56'd0, alu_inbus}, 64'd3);
        drain();

        // Reset in the middle of a multiply (pointer currently at requester 1).
        req0 = 1'b1; op0 = 2'b10; a0 = 8'd7; b0 = 8'd9;
        wait_gnt(who, g);
        req0 = 1'b0;
        chk("t5_owner", 64'(who), 64'd0);
        repeat (22) @(negedge CLK);
        chk("t5_busy_mid", {63'd0, busy}, 64'd1);
        RST_N = 1'b0;
        #1;
        chk("t5_async_reset_outputs", 64'(outs), 64'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (50) @(negedge CLK);
        req0 = 1'b1; op0 = 2'b00; a0 = 8'h7F; b0 = 8'h02;
        wait_gnt(who, g);
        req0 = 1'b0;
        chk("t5_fresh_owner", 64'(who), 64'd0);
        expect_done(0, 16'h0081, g + 15);
        drain();

        // Multiply on requester 1.
        req1 = 1'b1; op1 = 2'b10; a1 = 8'h12; b1 = 8'h34;
        wait_gnt(who, g);
        req1 = 1'b0;
        chk("t2_owner", 64'(who), 64'd1);
        expect_done(1, 16'h03A8, g + 44);
        drain();

        // Operands changed while busy; request held so a second op follows.
        req0 = 1'b1; op0 = 2'b11; a0 = 8'd200; b0 = 8'd7;
        wait_gnt(who, g);
        chk("t6_owner", 64'(who), 64'd0);
        expect_done(0, 16'h041C, g + 44);
        g_prev = g;
        repeat (5) @(negedge CLK);
        op0 = 2'b01; a0 = 8'd50; b0 = 8'd8;
        wait_gnt(who, g);
        req0 = 1'b0;
        chk("t6_regrant_owner", 64'(who), 64'd0);
        chk("t6_regrant_gap", 64'(g - g_prev), 64'd46);
        expect_done(0, 16'h002A, g + 15);
        drain();
        chk("t6_res1_untouched", {48'd0, res1}, 64'h03A8);
        chk("t6_res0_final", {48'd0, res0}, 64'h002A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
